// File: rtl/aes128_key_schedule.sv
// Cached AES-128 key expansion: computes RK0..RK10 one per cycle after key_load_i,
// then serves RK[round_num_i] combinationally to the cipher core.
//
// state  | meaning
// IDLE   | no key loaded since reset; storage is zero
// EXPAND | one round key written per cycle, RK[exp_cnt_q] from RK[exp_cnt_q-1]
// READY  | all NR+1 round keys valid; storage static until the next key_load_i
module aes128_key_schedule #(
   parameter int NR = 10
) (
   input  logic         clk_sys_i,
   input  logic         rst_i,
   input  logic [127:0] cipher_key_i,
   input  logic         key_load_i,
   input  logic [3:0]   round_num_i,
   output logic [127:0] round_key_o,
   output logic         key_ready_o,
   output logic         key_busy_o
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      EXPAND = 2'd1,
      READY  = 2'd2
   } state_t;

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry x sits at bit offset 8*(255-x), which is {~x, 3'b000}.
   function automatic logic [7:0] sbox(input logic [7:0] x);
      return SBOX[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   state_t        state_q;
   logic [3:0]    exp_cnt_q;
   logic [7:0]    rcon_q;
   logic [7:0]    rcon_d;
   logic          key_ready_q;
   logic [127:0]  rk_q [0:NR];
   logic [127:0]  prev_rk;
   logic [127:0]  rk_d;
   logic [31:0]   w0, w1, w2, w3;
   logic [31:0]   temp_w;
   logic [31:0]   nw0, nw1, nw2, nw3;

   always_comb begin
      prev_rk = '0;
      for (int i = 1; i <= NR; i++) begin
         if (exp_cnt_q == 4'(i)) prev_rk = rk_q[i-1];
      end
   end

   assign w0     = prev_rk[127:96];
   assign w1     = prev_rk[95:64];
   assign w2     = prev_rk[63:32];
   assign w3     = prev_rk[31:0];
   assign temp_w = sub_word({w3[23:0], w3[31:24]}) ^ {rcon_q, 24'h0};
   assign nw0    = w0 ^ temp_w;
   assign nw1    = w1 ^ nw0;
   assign nw2    = w2 ^ nw1;
   assign nw3    = w3 ^ nw2;
   assign rk_d   = {nw0, nw1, nw2, nw3};
   assign rcon_d = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

   always_ff @(posedge clk_sys_i) begin
      if (rst_i) begin
         state_q     <= IDLE;
         exp_cnt_q   <= '0;
         rcon_q      <= 8'h01;
         key_ready_q <= 1'b0;
         for (int i = 0; i <= NR; i++) rk_q[i] <= '0;
      end else if (key_load_i) begin
         // A load in any state restarts from the new key; partial results are overwritten.
         rk_q[0]     <= cipher_key_i;
         exp_cnt_q   <= 4'd1;
         rcon_q      <= 8'h01;
         state_q     <= EXPAND;
         key_ready_q <= 1'b0;
      end else begin
         case (state_q)
            EXPAND: begin
               for (int i = 1; i <= NR; i++) begin
                  if (exp_cnt_q == 4'(i)) rk_q[i] <= rk_d;
               end
               rcon_q <= rcon_d;
               if (exp_cnt_q == 4'(NR)) begin
                  state_q     <= READY;
                  key_ready_q <= 1'b1;
                  exp_cnt_q   <= '0;
               end else begin
                  exp_cnt_q <= exp_cnt_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      round_key_o = '0;
      for (int i = 0; i <= NR; i++) begin
         if (round_num_i == 4'(i)) round_key_o = rk_q[i];
      end
   end

   assign key_ready_o = key_ready_q;
   assign key_busy_o  = (state_q == EXPAND);

endmodule

// File: tb/tb_aes128_key_schedule.sv
// Scoreboard bench for aes128_key_schedule: expected schedules come from a FIPS-style
// word expansion over a GF(2^8)-derived S-box and are checked whenever key_ready is high.
module tb_aes128_key_schedule;

   typedef logic [10:0][127:0] sched_t;

   localparam logic [127:0] KEY_A  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
   localparam logic [127:0] A_RK1  = 128'ha0fafe1788542cb123a339392a6c7605;
   localparam logic [127:0] A_RK10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
   localparam logic [127:0] Z_RK1  = 128'h62636363626363636263636362636363;
   localparam logic [127:0] Z_RK10 = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;
   localparam logic [127:0] PT_A   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_A   = 128'h3925841d02dc09fbdc118597196a0b32;

   logic         clk_sys = 1'b0;
   logic         rst = 1'b1;
   logic [127:0] cipher_key = '0;
   logic         key_load = 1'b0;
   logic [3:0]   round_num = '0;
   logic [127:0] round_key;
   logic         key_ready;
   logic         key_busy;

   int           n_cmp = 0;
   int           n_bad = 0;
   logic [7:0]   sbox_m [256];
   sched_t       exp_q [$];

   aes128_key_schedule dut (
      .clk_sys_i    (clk_sys),
      .rst_i        (rst),
      .cipher_key_i (cipher_key),
      .key_load_i   (key_load),
      .round_num_i  (round_num),
      .round_key_o  (round_key),
      .key_ready_o  (key_ready),
      .key_busy_o   (key_busy)
   );

   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p = 8'h00; aa = a; bb = b;
      for (int k = 0; k < 8; k++) begin
         if (bb[0]) p = p ^ aa;
         aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
         bb = bb >> 1;
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box = affine transform of the multiplicative inverse in GF(2^8).
   task automatic init_sbox();
      logic [7:0] inv, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++) begin
            if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         end
         s = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
         sbox_m[x] = s;
      end
   endtask

   function automatic sched_t expand(input logic [127:0] key);
      logic [31:0] w [44];
      logic [31:0] tmp;
      logic [7:0]  rc;
      sched_t      s;
      for (int i = 0; i < 4; i++) w[i] = key[127 - 32*i -: 32];
      rc = 8'h01;
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {tmp[23:0], tmp[31:24]};
            tmp = {sbox_m[tmp[31:24]], sbox_m[tmp[23:16]], sbox_m[tmp[15:8]], sbox_m[tmp[7:0]]}
                  ^ {rc, 24'h0};
            rc = gmul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 11; r++) s[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
      return s;
   endfunction

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input sched_t rk);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   a0, a1, a2, a3;
      logic [127:0] blk;
      blk = pt ^ rk[0];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int i = 0; i < 16; i++) s[i] = sbox_m[blk[127 - 8*i -: 8]];
         for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++) t[r + 4*c] = s[r + 4*((c + r) % 4)];
         for (int c = 0; c < 4; c++) begin
            a0 = t[4*c]; a1 = t[4*c+1]; a2 = t[4*c+2]; a3 = t[4*c+3];
            if (rd < 10) begin
               s[4*c]   = gmul(a0, 8'h02) ^ gmul(a1, 8'h03) ^ a2 ^ a3;
               s[4*c+1] = a0 ^ gmul(a1, 8'h02) ^ gmul(a2, 8'h03) ^ a3;
               s[4*c+2] = a0 ^ a1 ^ gmul(a2, 8'h02) ^ gmul(a3, 8'h03);
               s[4*c+3] = gmul(a0, 8'h03) ^ a1 ^ a2 ^ gmul(a3, 8'h02);
            end else begin
               s[4*c] = a0; s[4*c+1] = a1; s[4*c+2] = a2; s[4*c+3] = a3;
            end
         end
         for (int i = 0; i < 16; i++) blk[127 - 8*i -: 8] = s[i];
         blk = blk ^ rk[rd];
      end
      return blk;
   endfunction

   // Called at a falling edge; the load is sampled on the following rising edge (E0).
   task automatic do_load(input logic [127:0] k);
      cipher_key = k;
      key_load   = 1'b1;
      @(negedge clk_sys);
      key_load   = 1'b0;
      cipher_key = {$urandom, $urandom, $urandom, $urandom};
   endtask

   // Entered just after E0; key_ready must appear exactly after E10 with key_busy high before it.
   task automatic wait_ready(input string tag);
      int n = 0;
      int busy_bad = 0;
      while (!key_ready && n < 20) begin
         if (key_busy !== 1'b1) busy_bad++;
         @(negedge clk_sys);
         n++;
      end
      chk({tag, "_latency"}, 128'(n), 128'd10);
      chk({tag, "_busy_during"}, 128'(busy_bad), 128'd0);
      chk({tag, "_ready"}, 128'(key_ready), 128'd1);
      chk({tag, "_busy_after"}, 128'(key_busy), 128'd0);
   endtask

   task automatic sweep();
      for (int r = 0; r < 16; r++) begin
         round_num = 4'(r);
         @(negedge clk_sys);
      end
      repeat (8) begin
         round_num = 4'($urandom_range(0, 15));
         @(negedge clk_sys);
      end
   endtask

   task automatic kat(input string tag, input logic [3:0] rn, input logic [127:0] exp);
      @(negedge clk_sys);
      round_num = rn;
      #2;
      chk(tag, round_key, exp);
   endtask

   task automatic chk_all_zero(input string tag);
      for (int r = 0; r < 16; r++) begin
         @(negedge clk_sys);
         round_num = 4'(r);
         #2;
         chk({tag, "_rk_zero"}, round_key, 128'h0);
      end
      @(negedge clk_sys);
   endtask

   task automatic read_rk(output sched_t got);
      for (int r = 0; r < 11; r++) begin
         @(negedge clk_sys);
         round_num = 4'(r);
         #2;
         got[r] = round_key;
      end
      @(negedge clk_sys);
   endtask

   // Monitor: each rising key_ready consumes one expected schedule; every cycle with
   // key_ready high compares round_key against it for the current round_num.
   logic   prev_rdy = 1'b0;
   bit     have_s = 1'b0;
   sched_t cur_s;
   initial begin
      forever begin
         @(negedge clk_sys);
         #1;
         if (key_ready && !prev_rdy) begin
            if (exp_q.size() == 0) begin
               have_s = 1'b0;
               chk("sb_unexpected_ready", 128'(exp_q.size()), 128'd1);
            end else begin
               cur_s  = exp_q.pop_front();
               have_s = 1'b1;
            end
         end
         if (key_ready && have_s) begin
            if (round_num <= 4'd10) chk("sb_round_key", round_key, cur_s[round_num]);
            else                   chk("sb_round_key_oob", round_key, 128'h0);
         end
         prev_rdy = key_ready;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   initial begin
      sched_t     got;
      logic [127:0] k1, k2;
      init_sbox();
      repeat (3) @(negedge clk_sys);
      rst = 1'b0;
      chk("reset_ready", 128'(key_ready), 128'd0);
      chk("reset_busy", 128'(key_busy), 128'd0);
      chk_all_zero("reset");

      // FIPS-197 App.A key, plus the full encryption through the served round keys.
      exp_q.push_back(expand(KEY_A));
      do_load(KEY_A);
      wait_ready("keyA");
      kat("keyA_rk1", 4'd1, A_RK1);
      kat("keyA_rk10", 4'd10, A_RK10);
      read_rk(got);
      chk("keyA_cipher_text", aes_enc(PT_A, got), CT_A);
      sweep();

      exp_q.push_back(expand(128'h0));
      do_load(128'h0);
      wait_ready("zero");
      kat("zero_rk1", 4'd1, Z_RK1);
      kat("zero_rk10", 4'd10, Z_RK10);
      @(negedge clk_sys);
      sweep();

      // Restart: zero key at E0, App.A key reloaded at E4.
      do_load(128'h0);
      repeat (3) @(negedge clk_sys);
      exp_q.push_back(expand(KEY_A));
      do_load(KEY_A);
      wait_ready("restart");
      kat("restart_rk10", 4'd10, A_RK10);
      @(negedge clk_sys);
      sweep();

      for (int it = 0; it < 4; it++) begin
         k1 = {$urandom, $urandom, $urandom, $urandom};
         exp_q.push_back(expand(k1));
         do_load(k1);
         wait_ready("rand");
         sweep();
      end

      k1 = {$urandom, $urandom, $urandom, $urandom};
      k2 = {$urandom, $urandom, $urandom, $urandom};
      do_load(k1);
      repeat ($urandom_range(0, 8)) @(negedge clk_sys);
      exp_q.push_back(expand(k2));
      do_load(k2);
      wait_ready("abort");
      sweep();

      // Reset at E5 mid-expansion.
      do_load(KEY_A);
      repeat (4) @(negedge clk_sys);
      rst = 1'b1;
      @(negedge clk_sys);
      rst = 1'b0;
      chk("midrst_ready", 128'(key_ready), 128'd0);
      chk("midrst_busy", 128'(key_busy), 128'd0);
      chk_all_zero("midrst");

      // Reset and load in the same cycle: reset wins, nothing expands.
      rst        = 1'b1;
      key_load   = 1'b1;
      cipher_key = KEY_A;
      @(negedge clk_sys);
      rst      = 1'b0;
      key_load = 1'b0;
      chk("rstload_busy", 128'(key_busy), 128'd0);
      chk("rstload_ready", 128'(key_ready), 128'd0);
      repeat (12) @(negedge clk_sys);
      chk("rstload_ready_later", 128'(key_ready), 128'd0);
      chk("rstload_busy_later", 128'(key_busy), 128'd0);
      chk_all_zero("rstload");

      repeat (2) @(negedge clk_sys);
      chk("sb_queue_empty", 128'(exp_q.size()), 128'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
